// File: rtl/seven_segm_ctl.sv
// Bus-mapped seven-segment controller: NUM_DIGITS active-low hex digits with blanking, LZS, blink, read-back.
// Latency: register write at edge N shows on HEX after edge N+1; read data valid one cycle after rd.
// Backpressure: none, every wr/rd strobe is accepted on its cycle (back-to-back allowed).
// Optional blink engine is built only when SEVEN_SEGM_BLINK_EN is defined.
module seven_segm_ctl #(
  parameter int ADDRESS           = 0,
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int NUM_DIGITS        = 8,
  parameter int BLINK_DIV         = 25000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic [7*NUM_DIGITS-1:0]      HEX
);

  localparam int NB = NUM_DIGITS / 2;

  typedef logic [BUS_ADDR_DATA_LEN-1:0] addr_t;

  localparam addr_t BASE      = addr_t'(ADDRESS);
  localparam addr_t OFF_BLANK = addr_t'(NB);
  localparam addr_t OFF_CTRL  = addr_t'(NB + 1);
  localparam addr_t OFF_BLINK = addr_t'(NB + 2);

  // Nibble i of data_q is digit i; byte k of data_q is DATA[k].
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    lzs_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    phase_q;

  addr_t                   off;
  logic                    in_win;
  logic [7:0]              rd_val;
  logic [7*NUM_DIGITS-1:0] hex_next;

  // The base check keeps addresses below the window from wrapping into it.
  assign off    = addr - BASE;
  assign in_win = (addr >= BASE) && (off <= OFF_BLINK);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Register file writes: DATA bytes, BLANK mask and the LZS control bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      blank_q <= '1;
      lzs_q   <= 1'b0;
    end else if (wr && in_win) begin
      for (int k = 0; k < NB; k++) begin
        if (off == addr_t'(k)) data_q[8*k +: 8] <= bus_in;
      end
      if (off == OFF_BLANK) blank_q <= bus_in[NUM_DIGITS-1:0];
      if (off == OFF_CTRL)  lzs_q   <= bus_in[0];
    end
  end

`ifdef SEVEN_SEGM_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] blink_cnt;
  logic          wr_blink;

  assign wr_blink = wr && in_win && (off == OFF_BLINK);

  // Blink mask plus free-running half-period counter; a BLINK write restarts in the visible phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q   <= '0;
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (wr_blink) begin
      blink_q   <= bus_in[NUM_DIGITS-1:0];
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase_q   <= ~phase_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  // Without the blink engine the mask is permanently clear and nothing ever blinks.
  assign blink_q = '0;
  assign phase_q = 1'b0;
`endif

  // Read mux over the current (pre-write) register contents; unmapped bits read 0.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NB; k++) begin
      if (off == addr_t'(k)) rd_val = data_q[8*k +: 8];
    end
    if (off == OFF_BLANK) rd_val = 8'(blank_q);
    if (off == OFF_CTRL)  rd_val = {7'b0, lzs_q};
    if (off == OFF_BLINK) rd_val = 8'(blink_q);
  end

  // Registered read port; drives 0 when idle so it can be OR-ed onto a shared bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_out <= '0;
    end else begin
      bus_out <= (rd && in_win) ? rd_val : 8'h00;
    end
  end

  // Per-digit display: walk from the top digit down so all_zero covers digit i and everything above it.
  always_comb begin
    logic all_zero;
    logic dark;
    hex_next = '1;
    all_zero = 1'b1;
    dark     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (data_q[4*i +: 4] == 4'h0);
      dark     = blank_q[i]
               || (lzs_q && (i > 0) && all_zero)
               || (blink_q[i] && phase_q);
      hex_next[7*i +: 7] = dark ? 7'h7F : seg_decode(data_q[4*i +: 4]);
    end
  end

  // Segment outputs registered; reset forces every digit dark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      HEX <= '1;
    end else begin
      HEX <= hex_next;
    end
  end

endmodule

// File: tb/tb_seven_segm_ctl.sv
// Directed bench for seven_segm_ctl: decode table, blanking, LZS, read-back, window edges, blink and async reset.
// Expected segment values are hand-computed constants.
module tb_seven_segm_ctl;

  localparam int ND   = 8;
  localparam int NB   = ND / 2;
  localparam int AW   = 16;
  localparam int BASE = 'h0120;
  localparam int BDIV = 4;

`ifdef SEVEN_SEGM_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam int OFF_BLANK = NB;
  localparam int OFF_CTRL  = NB + 1;
  localparam int OFF_BLINK = NB + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          wr;
  logic          rd;
  logic [7:0]    bus_in;
  logic [7:0]    bus_out;
  logic [7*ND-1:0] hex;

  int n_checks = 0;
  int n_pass   = 0;

  seven_segm_ctl #(
    .ADDRESS(BASE),
    .BUS_ADDR_DATA_LEN(AW),
    .NUM_DIGITS(ND),
    .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wr(wr),
    .rd(rd),
    .bus_in(bus_in),
    .bus_out(bus_out),
    .HEX(hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic [6:0] d0;
    logic [6:0] d1;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] dig(input int i);
    return hex[7*i +: 7];
  endfunction

  task automatic write_reg(input int off, input logic [7:0] val);
    @(negedge clk);
    addr   = AW'(BASE + off);
    bus_in = val;
    wr     = 1'b1;
    @(negedge clk);
    wr     = 1'b0;
  endtask

  task automatic write_abs(input logic [AW-1:0] a, input logic [7:0] val);
    @(negedge clk);
    addr   = a;
    bus_in = val;
    wr     = 1'b1;
    @(negedge clk);
    wr     = 1'b0;
  endtask

  task automatic read_reg(input int off, output logic [7:0] val);
    @(negedge clk);
    addr = AW'(BASE + off);
    rd   = 1'b1;
    @(negedge clk);
    rd   = 1'b0;
    val  = bus_out;
  endtask

  task automatic read_check(input string name, input int off, input logic [7:0] exp);
    logic [7:0] v;
    read_reg(off, v);
    check(name, 64'(v), 64'(exp));
  endtask

  // Samples after each of n edges following a BLINK write; digit0 dark during odd half-periods.
  task automatic blink_run(input int n);
    logic [6:0] exp0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      exp0 = (BLINK_EN && ((((j - 1) / BDIV) % 2) == 1)) ? 7'h7F : 7'h40;
      check($sformatf("blink_d0_%0d", j), 64'(dig(0)), 64'(exp0));
      check($sformatf("blink_d1_%0d", j), 64'(dig(1)), 64'(7'h40));
    end
  endtask

  initial begin
    logic [7:0] v;

    vecs[0] = '{8'h10, 7'h40, 7'h79};
    vecs[1] = '{8'h32, 7'h24, 7'h30};
    vecs[2] = '{8'h54, 7'h19, 7'h12};
    vecs[3] = '{8'h76, 7'h02, 7'h78};
    vecs[4] = '{8'h98, 7'h00, 7'h10};
    vecs[5] = '{8'hBA, 7'h08, 7'h03};
    vecs[6] = '{8'hDC, 7'h46, 7'h21};
    vecs[7] = '{8'hFE, 7'h06, 7'h0E};
    vecs[8] = '{8'hA5, 7'h12, 7'h08};

    rst    = 1'b0;
    addr   = '0;
    wr     = 1'b0;
    rd     = 1'b0;
    bus_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset_hex", 64'(hex), 64'({ND{7'h7F}}));
    check("reset_bus_out", 64'(bus_out), 64'(0));
    read_check("reset_blank", OFF_BLANK, 8'hFF);
    @(negedge clk);
    check("idle_bus_out", 64'(bus_out), 64'(0));

    // Unblank: all-zero data shows '0' everywhere
    write_reg(OFF_BLANK, 8'h00);
    @(negedge clk);
    check("unblank_hex", 64'(hex), 64'({ND{7'h40}}));

    // Decode table through DATA[0]
    for (int t = 0; t < 9; t++) begin
      write_reg(0, vecs[t].dat);
      @(negedge clk);
      check($sformatf("vec%0d_d0", t), 64'(dig(0)), 64'(vecs[t].d0));
      check($sformatf("vec%0d_d1", t), 64'(dig(1)), 64'(vecs[t].d1));
      read_check($sformatf("vec%0d_rd", t), 0, vecs[t].dat);
    end

    // Per-digit blanking
    write_reg(OFF_BLANK, 8'h01);
    @(negedge clk);
    check("blank_d0", 64'(dig(0)), 64'(7'h7F));
    check("blank_d1", 64'(dig(1)), 64'(7'h08));
    write_reg(OFF_BLANK, 8'h00);

    // Leading-zero suppression
    write_reg(0, 8'h05);
    write_reg(OFF_CTRL, 8'hFF);
    @(negedge clk);
    check("lzs_on", 64'(hex), 64'({{7{7'h7F}}, 7'h12}));
    read_check("ctrl_rd", OFF_CTRL, 8'h01);
    write_reg(OFF_CTRL, 8'h00);
    @(negedge clk);
    check("lzs_off", 64'(hex), 64'({{7{7'h40}}, 7'h12}));
    write_reg(OFF_CTRL, 8'h01);
    write_reg(1, 8'h01);
    @(negedge clk);
    check("lzs_mid", 64'(hex), 64'({{5{7'h7F}}, 7'h79, 7'h40, 7'h12}));
    write_reg(OFF_CTRL, 8'h00);

    // Simultaneous write and read returns the old value
    write_reg(1, 8'h12);
    @(negedge clk);
    addr   = AW'(BASE + 1);
    bus_in = 8'h34;
    wr     = 1'b1;
    rd     = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    check("wr_rd_old", 64'(bus_out), 64'(8'h12));
    @(negedge clk);
    check("wr_rd_idle", 64'(bus_out), 64'(0));
    read_check("wr_rd_new", 1, 8'h34);

    // Accesses just outside the window
    write_reg(NB + 3, 8'hFF);
    write_abs(AW'(BASE - 1), 8'hFF);
    @(negedge clk);
    check("oow_hex", 64'(hex), 64'({{4{7'h40}}, 7'h30, 7'h19, 7'h40, 7'h12}));
    read_check("oow_blank", OFF_BLANK, 8'h00);
    read_check("oow_ctrl", OFF_CTRL, 8'h00);
    read_check("oow_data0", 0, 8'h05);
    read_check("oow_read", NB + 3, 8'h00);

    // Blink: visible half-period first, restart on a second BLINK write
    write_reg(0, 8'h00);
    write_reg(1, 8'h00);
    write_reg(OFF_BLINK, 8'h01);
    blink_run(6);
    write_reg(OFF_BLINK, 8'h01);
    blink_run(10);
    read_check("blink_rd", OFF_BLINK, BLINK_EN ? 8'h01 : 8'h00);

    // Asynchronous reset mid-operation, between clock edges
    write_reg(0, 8'hA5);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_hex", 64'(hex), 64'({ND{7'h7F}}));
    check("arst_bus_out", 64'(bus_out), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    read_check("post_data0", 0, 8'h00);
    read_check("post_data1", 1, 8'h00);
    read_check("post_blank", OFF_BLANK, 8'hFF);
    read_check("post_ctrl", OFF_CTRL, 8'h00);
    read_check("post_blink", OFF_BLINK, 8'h00);
    check("post_hex", 64'(hex), 64'({ND{7'h7F}}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_segm_ctl.md
# seven_segm_ctl

Parametrised, bus-mapped seven-segment display controller, successor to the fixed eight-digit writer. Drives NUM_DIGITS active-low hex digits from byte-wide nibble-pair registers. Adds per-digit blanking, leading-zero suppression, per-digit blinking and registered read-back. Sits on the shared 8-bit data / BUS_ADDR_DATA_LEN-bit address peripheral bus next to the other memory-mapped blocks.

## Interface
- ADDRESS, 0, base bus address of the register window
- BUS_ADDR_DATA_LEN, 16, address bus width
- NUM_DIGITS, 8, digit count; even, 2..8
- BLINK_DIV, 25000000, clk cycles per blink half-period; ≥2
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- addr  input  BUS_ADDR_DATA_LEN  bus address
- wr  input  1  write strobe, one cycle per write
- rd  input  1  read strobe, one cycle per read
- bus_in  input  8  write data
- bus_out  output  8  read data, registered
- HEX  output  7*NUM_DIGITS  segments; digit i at [7i+6:7i], bit0=a … bit6=g, 0 = lit

## Operation
- NB = NUM_DIGITS/2. Window is ADDRESS .. ADDRESS+NB+2. Accesses outside it are ignored.
- Offset k < NB: DATA[k]. Bits [3:0] hold digit 2k, bits [7:4] hold digit 2k+1.
- Offset NB, BLANK: bit i forces digit i dark (7'h7F).
- Offset NB+1, CTRL: bit0 LZS enables leading-zero suppression. Other bits write-ignored, read 0.
- Offset NB+2, BLINK: bit i marks digit i as blinking.
- Mask bits ≥ NUM_DIGITS are write-ignored and read 0.
- Decode is hex 0–F: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (7-bit hex).
- Digit i is dark if any of these holds:
  - BLANK[i] is set;
  - LZS=1, i>0, and the nibbles of digit i and every higher-index digit are all 0 (digit 0 is never suppressed);
  - BLINK[i]=1 and blink phase = 1.
- Otherwise digit i shows the decode of its nibble.
- Blink engine: a counter 0..BLINK_DIV-1. Phase toggles when the counter wraps.
- Any write to BLINK clears the counter and sets phase to 0 (visible).
- Read: rd in window loads bus_out with the register value. A mapped offset with no register returns 0. With no in-window rd, bus_out = 0, so the block can be OR-ed onto a shared return bus.
- wr and rd on the same cycle and same address: bus_out gets the pre-write value.

## Timing
- Reset (rst=0, asynchronous), applied mid-operation at any time:
  - DATA=0, BLANK=all ones, CTRL=0, BLINK=0;
  - counter=0, phase=0;
  - HEX=all 7'h7F, bus_out=0.
- Register write takes effect on the clk edge where wr=1.
- HEX is registered and reflects new state on the next edge: write at edge N, HEX updated at edge N+1.
- Read latency is 1: rd at edge N, bus_out valid after edge N, for one cycle.
- Blink phase toggles when the counter wraps from BLINK_DIV-1 to 0. The HEX change follows one edge later.
- Back-to-back writes on consecutive cycles are all accepted.

## Configuration
- SEVEN_SEGM_BLINK_EN defined: blink counter, phase and BLINK register are present as described.
- Not defined: no counter is built, BLINK writes are ignored, BLINK reads 0 and no digit ever blinks. The address map is unchanged.

## Test plan
- Reset released, no writes → HEX all 7'h7F. Read of BLANK offset (NB) returns 8'hFF for NUM_DIGITS=8; bus_out=0 when idle.
- Write BLANK=0, DATA[0]=8'hA5 → one edge later digit0=7'h12, digit1=7'h08. Read DATA[0] returns 8'hA5 one cycle after rd.
- NUM_DIGITS=8, DATA = 00,00,00,05 at offsets 3..0, CTRL=1, BLANK=0 → digit0 shows 7'h12, digits 1–7 show 7'h7F. Set CTRL=0 → digits 1–7 show 7'h40.
- BLINK_DIV=4, BLINK=8'h01, BLANK=0, DATA[0]=8'h00 → digit0 alternates 7'h40 / 7'h7F every 4 cycles, starting visible from the BLINK write; digit1 stays 7'h40. Without SEVEN_SEGM_BLINK_EN, digit0 stays 7'h40 and a BLINK read returns 0.
- wr and rd on DATA[1], old value 8'h12, new 8'h34 → bus_out=8'h12; the next read returns 8'h34. A write to ADDRESS+NB+3 changes nothing.
- rst pulled low mid-blink with digits lit → HEX goes 7'h7F immediately, without waiting for clk; all registers read back their reset values after release.
